boot_loader_ctrl: RTL and testbench

Sequences the instruction-memory bootloader path of the fetch stage. Receives a framed byte stream (from the UART receiver) and packs it into 32-bit words. Drives the fetch stage's `boot_addr`/`boot_data`/`debug` write port one word at a time. Holds the CPU off (`cpu_hold`) until a complete image has been loaded and checksum-verified.

---
 rtl/boot_loader_ctrl_pkg.sv | 23 ++
 rtl/boot_loader_ctrl_word_pack.sv | 48 ++++
 rtl/boot_loader_ctrl.sv | 168 ++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the instruction-memory bootloader.
// Frame: MAGIC, LEN_LO, LEN_HI, LEN*4 little-endian data bytes, XOR checksum.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } boot_state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int LEN_W = 16;
  localparam int IDX_W = 13;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_word_pack.sv
// Packs a byte stream into little-endian 32-bit words; word_valid pulses
// for one cycle after the edge that accepts the fourth byte of a word.
module boot_word_pack
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_fire
);

  logic [1:0]  cnt_r;
  logic [31:0] shift_r;
  logic [31:0] word_r;
  logic        word_valid_r;

  assign word_fire  = byte_valid && (cnt_r == 2'd3);
  assign word       = word_r;
  assign word_valid = word_valid_r;

  // Byte counter, shift register and registered word output
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 2'd0;
      shift_r      <= 32'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (clear) begin
        cnt_r   <= 2'd0;
        shift_r <= 32'd0;
      end else if (byte_valid) begin
        cnt_r   <= cnt_r + 2'd1;
        shift_r <= {byte_in, shift_r[31:8]};
        if (word_fire) begin
          word_r       <= {byte_in, shift_r[31:8]};
          word_valid_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Bootloader sequencer: parses framed bytes, writes words to instruction
// memory and releases the CPU only after a checksum-verified image.
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int         MEM_WORDS      = 8192,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] boot_addr,
  output logic [31:0] boot_data,
  output logic        debug,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        boot_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  boot_state_t      state_r;
  boot_state_t      state_s;
  logic [7:0]       len_lo_r;
  logic [LEN_W-1:0] len_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] addr_r;
  logic [7:0]       acc_r;
  logic [TMO_W-1:0] idle_r;
  logic             hold_r;
  logic             done_r;
  logic             err_r;

  logic [LEN_W-1:0] len_s;
  logic             magic_s;
  logic             in_frame_s;
  logic             timeout_s;
  logic             pack_valid_s;
  logic             pack_clear_s;
  logic             word_fire_s;
  logic             last_word_s;
  logic [31:0]      pack_word_s;
  logic             pack_word_valid_s;

  assign len_s        = {rx_data, len_lo_r};
  assign magic_s      = rx_valid && (rx_data == MAGIC);
  assign in_frame_s   = (state_r == ST_LEN_LO) || (state_r == ST_LEN_HI) ||
                        (state_r == ST_DATA)   || (state_r == ST_CHK);
  assign timeout_s    = in_frame_s && !rx_valid && (idle_r == TMO_W'(TIMEOUT_CYCLES - 1));
  assign pack_valid_s = rx_valid && (state_r == ST_DATA);
  assign pack_clear_s = rx_valid && (state_r == ST_LEN_HI);
  assign last_word_s  = ({{(LEN_W-IDX_W){1'b0}}, idx_r} == (len_r - 16'd1));

  boot_word_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear_s),
    .byte_valid (pack_valid_s),
    .byte_in    (rx_data),
    .word       (pack_word_s),
    .word_valid (pack_word_valid_s),
    .word_fire  (word_fire_s)
  );

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (magic_s) state_s = ST_LEN_LO;
        else         state_s = ST_IDLE;
      end
      ST_LEN_LO: begin
        if (timeout_s)     state_s = ST_ERR;
        else if (rx_valid) state_s = ST_LEN_HI;
        else               state_s = ST_LEN_LO;
      end
      ST_LEN_HI: begin
        if (timeout_s) begin
          state_s = ST_ERR;
        end else if (rx_valid) begin
          // Oversized images are rejected before any word is written
          if ({16'd0, len_s} > 32'(MEM_WORDS)) state_s = ST_ERR;
          else if (len_s == 16'd0)             state_s = ST_CHK;
          else                                 state_s = ST_DATA;
        end else begin
          state_s = ST_LEN_HI;
        end
      end
      ST_DATA: begin
        if (timeout_s)                       state_s = ST_ERR;
        else if (word_fire_s && last_word_s) state_s = ST_CHK;
        else                                 state_s = ST_DATA;
      end
      ST_CHK: begin
        if (timeout_s)     state_s = ST_ERR;
        else if (rx_valid) state_s = (rx_data == acc_r) ? ST_DONE : ST_ERR;
        else               state_s = ST_CHK;
      end
      ST_DONE, ST_ERR: begin
        if (magic_s) state_s = ST_LEN_LO;
        else         state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      hold_r  <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      hold_r  <= (state_s != ST_DONE);
      done_r  <= (state_s == ST_DONE);
      err_r   <= (state_s == ST_ERR);
    end
  end

  // Length capture, word index, write address and checksum accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_r <= 8'd0;
      len_r    <= 16'd0;
      idx_r    <= 13'd0;
      addr_r   <= 13'd0;
      acc_r    <= 8'd0;
    end else begin
      if ((state_r == ST_LEN_LO) && rx_valid) len_lo_r <= rx_data;
      if (pack_clear_s) begin
        len_r <= len_s;
        idx_r <= 13'd0;
        acc_r <= 8'd0;
      end else if (pack_valid_s) begin
        acc_r <= chk_update(acc_r, rx_data);
        if (word_fire_s) begin
          addr_r <= idx_r;
          // Index parks at LEN-1 so it can never wrap
          if (!last_word_s) idx_r <= idx_r + 13'd1;
        end
      end
    end
  end

  // Inter-byte idle counter, active only inside a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_r <= '0;
    end else if (in_frame_s && !rx_valid) begin
      idle_r <= idle_r + TMO_W'(1);
    end else begin
      idle_r <= '0;
    end
  end

  assign boot_addr = {19'd0, addr_r};
  assign boot_data = pack_word_s;
  assign debug     = pack_word_valid_s;
  assign cpu_hold  = hold_r;
  assign boot_done = done_r;
  assign boot_err  = err_r;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: frames are modelled as byte lists,
// expected writes/status are queued, and a negedge monitor checks them.
module tb_boot_loader_ctrl;

  localparam int TMO = 100;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] boot_addr;
  logic [31:0] boot_data;
  logic        debug;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_err;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic done; logic err; } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  checks;
  int  failures;
  logic prev_flag;

  boot_loader_ctrl #(.MEM_WORDS(8192), .MAGIC(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .boot_addr(boot_addr), .boot_data(boot_data), .debug(debug),
    .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_err(boot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes on debug and expected status on completion
  always @(negedge clk) begin
    if (debug === 1'b1) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check("write_addr", boot_addr, w.addr);
        check("write_data", boot_data, w.data);
      end
    end
    if ((boot_done | boot_err) === 1'b1 && prev_flag !== 1'b1) begin
      if (sq.size() == 0) begin
        check("unexpected_status", 32'd1, 32'd0);
      end else begin
        st_t s;
        s = sq.pop_front();
        check("status_done", {31'd0, boot_done}, {31'd0, s.done});
        check("status_err",  {31'd0, boot_err},  {31'd0, s.err});
        check("status_hold", {31'd0, cpu_hold},  {31'd0, !s.done});
      end
    end
    prev_flag = boot_done | boot_err;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((wq.size() != 0 || sq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", wq.size() + sq.size(), 32'd0);
  endtask

  task automatic push_status(input logic done, input logic err);
    st_t s;
    s.done = done;
    s.err  = err;
    sq.push_back(s);
  endtask

  // Reference frame: words chosen up front, writes/status derived from the frame rules.
  // stall_at >= 0 stops after that many data bytes and idles past the timeout.
  task automatic run_frame(input int len, input logic [31:0] words[$], input int chk_delta,
                           input int stall_at, input int max_gap);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    int nwr;
    chk = 8'h00;
    for (int w = 0; w < len; w++) begin
      for (int b = 0; b < 4; b++) begin
        logic [31:0] wd;
        wd = words[w];
        bytes.push_back(wd[8*b +: 8]);
        chk = chk ^ wd[8*b +: 8];
      end
    end
    nwr = (stall_at >= 0) ? stall_at / 4 : len;
    for (int i = 0; i < nwr; i++) begin
      wr_t e;
      e.addr = i;
      e.data = words[i];
      wq.push_back(e);
    end
    if (stall_at >= 0)       push_status(1'b0, 1'b1);
    else if (chk_delta != 0) push_status(1'b0, 1'b1);
    else                     push_status(1'b1, 1'b0);
    send_byte(8'hA5, $urandom_range(0, max_gap));
    send_byte(len[7:0], $urandom_range(0, max_gap));
    send_byte(len[15:8], $urandom_range(0, max_gap));
    for (int i = 0; i < bytes.size(); i++) begin
      if (stall_at >= 0 && i == stall_at) break;
      send_byte(bytes[i], $urandom_range(0, max_gap));
    end
    if (stall_at >= 0) repeat (TMO) @(negedge clk);
    else send_byte(chk ^ chk_delta[7:0], 0);
    drain(TMO + 50);
  endtask

  task automatic send_garbage(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] g;
      g = $urandom_range(0, 255);
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g, $urandom_range(0, 2));
    end
  endtask

  initial begin
    logic [31:0] words[$];
    checks    = 0;
    failures  = 0;
    prev_flag = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_hold",  {31'd0, cpu_hold},  32'd1);
    check("reset_done",  {31'd0, boot_done}, 32'd0);
    check("reset_err",   {31'd0, boot_err},  32'd0);
    check("reset_debug", {31'd0, debug},     32'd0);
    check("reset_addr",  boot_addr,          32'd0);
    check("reset_data",  boot_data,          32'd0);
    repeat (1000) @(negedge clk);
    check("idle_hold", {31'd0, cpu_hold},  32'd1);
    check("idle_done", {31'd0, boot_done}, 32'd0);

    // Garbage then the reference two-word frame
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h12, 0);
    words = '{32'h0000_0013, 32'h0000_0073};
    run_frame(2, words, 0, -1, 0);
    check("frameA_done", {31'd0, boot_done}, 32'd1);
    run_frame(2, words, 1, -1, 0);
    check("frameA_bad_hold", {31'd0, cpu_hold}, 32'd1);

    // Oversized length: error straight after LEN_HI, no writes
    push_status(1'b0, 1'b1);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    drain(20);

    // Timeout after the second data byte, then recovery
    words = '{$urandom, $urandom};
    run_frame(2, words, 0, 2, 0);
    words = '{$urandom, $urandom, $urandom};
    run_frame(3, words, 0, -1, 2);

    // Zero-length image with a zero checksum
    words = {};
    run_frame(0, words, 0, -1, 1);

    // Reset in the middle of a frame
    wq.push_back('{addr: 32'd0, data: 32'h0000_0013});
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h73, 0); send_byte(8'h00, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_hold",  {31'd0, cpu_hold},  32'd1);
    check("midreset_done",  {31'd0, boot_done}, 32'd0);
    check("midreset_debug", {31'd0, debug},     32'd0);
    @(negedge clk);
    check("midreset_debug2", {31'd0, debug}, 32'd0);
    drain(10);
    words = '{32'hDEAD_BEEF};
    run_frame(1, words, 0, -1, 0);

    // Randomised frames
    for (int it = 0; it < 30; it++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) send_garbage($urandom_range(1, 4));
      if (kind == 0) begin
        len = $urandom_range(8193, 65535);
        push_status(1'b0, 1'b1);
        send_byte(8'hA5, 0);
        send_byte(len[7:0], $urandom_range(0, 3));
        send_byte(len[15:8], 0);
        drain(20);
      end else begin
        len = (kind == 9) ? 0 : $urandom_range(1, 6);
        words = {};
        for (int w = 0; w < len; w++) words.push_back($urandom);
        if (kind == 1 && len > 0)
          run_frame(len, words, 0, $urandom_range(0, len * 4), 3);
        else if (kind <= 3)
          run_frame(len, words, $urandom_range(1, 255), -1, 3);
        else
          run_frame(len, words, 0, -1, 3);
      end
    end

    drain(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
